// File: rtl/thcattus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : thcattus_pkg
// Purpose  : Shared constants for the thcattus AXI-Stream FIFO slice.
// Contents : THCATTUS_AXIS_BYTES          - default stream width in bytes
//            THCATTUS_FIFO_DEPTH_DEFAULT  - default FIFO depth in words
//            THCATTUS_STALL_CNT_W         - width of the upstream stall counter
// Revision : 1.0 - initial release
// ============================================================================
package thcattus_pkg;

  localparam int THCATTUS_AXIS_BYTES         = 4;
  localparam int THCATTUS_FIFO_DEPTH_DEFAULT = 16;
  localparam int THCATTUS_STALL_CNT_W        = 16;

endpackage : thcattus_pkg
`default_nettype wire

// File: rtl/thcattus_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module   : thcattus_fifo_ram
// Purpose  : DEPTH x WIDTH storage array for the FIFO. Synchronous write,
//            asynchronous (combinational) read, no reset on the contents.
// Ports    : clk_i   - write clock
//            we_i    - write enable
//            waddr_i - write address
//            wdata_i - write data
//            raddr_i - read address
//            rdata_o - read data (combinational from raddr_i)
// Revision : 1.0 - initial release
// ============================================================================
module thcattus_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : thcattus_fifo_ram
`default_nettype wire

// File: rtl/thcattus_axis_fifo.sv
`default_nettype none
// ============================================================================
// Module   : thcattus_axis_fifo
// Purpose  : First-word-fall-through AXI-Stream FIFO with a saturating
//            upstream stall counter.
// Params   : DATA_WIDTH  - bus width in bytes (tdata is DATA_WIDTH*8 bits)
//            DEPTH       - words stored, power of two 2..256
//            AFULL_LEVEL - almost-full threshold in words
// Ports    : axis_aclk, axis_areset (async, active-high)
//            s_axis_tvalid/tready/tdata - upstream stream
//            m_axis_tvalid/tready/tdata - downstream stream
//            stall_clr   - synchronous clear of stall_count
//            stall_count - saturating count of upstream stall cycles
//            fill_level, almost_full - only with THCATTUS_AXIS_FIFO_LEVEL_EN
// Build    : define THCATTUS_AXIS_FIFO_LEVEL_EN to add the level ports.
// Revision : 1.0 - initial release
// ============================================================================
module thcattus_axis_fifo
  import thcattus_pkg::*;
#(
  parameter int DATA_WIDTH  = THCATTUS_AXIS_BYTES,
  parameter int DEPTH       = THCATTUS_FIFO_DEPTH_DEFAULT,
  parameter int AFULL_LEVEL = DEPTH - 2
) (
  input  logic                            axis_aclk,
  input  logic                            axis_areset,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [DATA_WIDTH*8-1:0]         s_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [DATA_WIDTH*8-1:0]         m_axis_tdata,
  input  logic                            stall_clr,
  output logic [THCATTUS_STALL_CNT_W-1:0] stall_count
`ifdef THCATTUS_AXIS_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]          fill_level,
  output logic                            almost_full
`endif
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = DEPTH[AW:0];

  logic [AW-1:0]                   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                   rd_ptr_q, rd_ptr_d;
  logic [AW:0]                     count_q,  count_d;
  logic [THCATTUS_STALL_CNT_W-1:0] stall_q,  stall_d;

  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_rd;

  // Flags come only from the registered count, so a full FIFO refuses a
  // write even when the downstream side drains a word in the same cycle.
  assign w_full  = (count_q == C_DEPTH);
  assign w_empty = (count_q == '0);

  assign s_axis_tready = ~w_full;
  assign m_axis_tvalid = ~w_empty;

  assign w_wr = s_axis_tvalid & ~w_full;
  assign w_rd = m_axis_tready & ~w_empty;

  always_comb begin
    // Pointers are exactly AW bits so they wrap from DEPTH-1 to 0 on their own.
    wr_ptr_d = w_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = w_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    case ({w_wr, w_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Clear wins over a same-cycle increment; the increment stops at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (stall_clr) begin
      stall_d = '0;
    end else if (s_axis_tvalid && w_full && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  assign stall_count = stall_q;

  // Asynchronous read of the head slot gives first-word fall-through; a word
  // written at edge N is visible after that edge, never in the same cycle.
  thcattus_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_WIDTH*8)
  ) u_ram (
    .clk_i   (axis_aclk),
    .we_i    (w_wr),
    .waddr_i (wr_ptr_q),
    .wdata_i (s_axis_tdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (m_axis_tdata)
  );

`ifdef THCATTUS_AXIS_FIFO_LEVEL_EN
  localparam logic [AW:0] C_AFULL = AFULL_LEVEL[AW:0];

  assign fill_level  = count_q;
  assign almost_full = (count_q >= C_AFULL);
`endif

endmodule : thcattus_axis_fifo
`default_nettype wire
